imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter IM_DEPTH, default 1024: instruction memory depth in 32-bit words.
REQ-002 Parameter ADDR_W, default 10: word address width (log2 IM_DEPTH).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 rx_data  input  8  byte from upstream serial receiver.
REQ-006 rx_valid  input  1  rx_data holds a byte; a byte transfers on a cycle with rx_valid=1 and rx_ready=1.
REQ-007 rx_ready  output  1  loader can accept a byte this cycle.
REQ-008 im_we  output  1  one-cycle write strobe to instruction memory.
REQ-009 im_addr  output  ADDR_W  word address for im_we.
REQ-010 im_wdata  output  32  instruction word for im_we.
REQ-011 cpu_run  output  1  1 = load complete and verified; drives the processor's run enable.
REQ-012 load_err  output  1  1 = load failed; sticky until reset.

Function
REQ-013 Byte stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes, then one checksum byte CS.
REQ-014 FSM states: S_LEN0, S_LEN1, S_DATA, S_CSUM, S_RUN, S_ERR.
REQ-015 rx_ready SHALL be 1 in S_LEN0, S_LEN1, S_DATA, S_CSUM and 0 in S_RUN, S_ERR.
REQ-016 S_LEN0 -> S_LEN1 on a transfer; rx_data is latched as N[7:0].
REQ-017 S_LEN1 on a transfer: latch N[15:8]; go to S_ERR if N > IM_DEPTH, to S_CSUM if N = 0, else to S_DATA.
REQ-018 S_DATA SHALL pack bytes little-endian: the first byte of each group goes to [7:0] and the fourth to [31:24].
REQ-019 On the transfer of the 4th byte of a group, im_we SHALL pulse high for exactly the next cycle, with im_wdata = packed word and im_addr = word index.
REQ-020 The word index SHALL start at 0 and increment by 1 after each im_we; no wrap is possible because N <= IM_DEPTH.
REQ-021 The running checksum SHALL be the XOR of all 4*N data bytes, cleared on entry to S_LEN0.
REQ-022 S_DATA -> S_CSUM on the 4th byte of word N-1.
REQ-023 S_CSUM on a transfer: go to S_RUN if rx_data equals the running checksum, else to S_ERR.
REQ-024 cpu_run SHALL be 1 only in S_RUN; load_err SHALL be 1 only in S_ERR.
REQ-025 S_RUN and S_ERR are terminal; only reset leaves them.
REQ-026 rx_valid=0 SHALL hold all state, including a partial packing group; no timeout.
REQ-027 im_we SHALL be 0 in every cycle other than those in REQ-019; im_addr/im_wdata are don't-care when im_we=0.
REQ-028 A back-to-back byte stream (rx_valid held 1) SHALL be accepted at 1 byte/cycle without stall.

Reset
REQ-029 reset=0 SHALL immediately force: state S_LEN0, rx_ready=0 while asserted, im_we=0, im_addr=0, im_wdata=0, cpu_run=0, load_err=0, counters and checksum 0.
REQ-030 Reset asserted mid-load SHALL abort the load; a pending im_we SHALL NOT be issued, and the next load restarts at address 0.

Structure
REQ-031 A shared package SHALL hold the state enum, the stream-format constants (LEN bytes = 2, bytes/word = 4), and the IM_DEPTH default.
REQ-032 A sub-module byte_packer SHALL hold the 2-bit byte counter and the 32-bit shift/assembly register, and flag word completion.

Verification
REQ-033 Stream 01 00 | 78 56 34 12 | 08 -> one im_we, addr 0, data 0x12345678; then cpu_run=1, rx_ready=0.
REQ-034 N=3 with words 0x00000001, 0x00000002, 0x00000003 and CS=0x00 -> im_we at addr 0,1,2 with those data; cpu_run=1.
REQ-035 Stream 00 00 | 00 -> no im_we; cpu_run=1.
REQ-036 Stream 01 04 (N=1025) with IM_DEPTH=1024 -> load_err=1, no im_we, rx_ready=0.
REQ-037 REQ-033 stream with CS=0x09 -> im_we at addr 0, then load_err=1, cpu_run stays 0.
REQ-038 reset=0 after 2 data bytes of a load, then the REQ-033 stream with random rx_valid gaps -> same result as REQ-033; no write from the aborted load.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM states and boot stream format constants for the instruction memory loader.
package imem_loader_pkg;
  localparam int LEN_BYTES = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int IM_DEPTH_DEF = 1024;
  typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_CSUM, S_RUN, S_ERR} state_t;
endpackage

// File: rtl/byte_packer.sv
// byte_packer: assembles bytes into little-endian 32-bit words and flags the last byte of each word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        done
);
  logic [1:0] cnt;
  assign done = en && cnt == 2'(BYTES_PER_WORD - 1);
  // Shifting in from the top leaves the first byte of a group in [7:0].
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt  <= '0;
      word <= '0;
    end else if (en) begin
      cnt  <= cnt + 2'd1;
      word <= {din, word[31:8]};
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed, XOR-checksummed byte stream, writes it to instruction
// memory and releases the processor only when the checksum matches.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IM_DEPTH = IM_DEPTH_DEF,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_run,
  output logic              load_err
);
  state_t      state;
  logic [15:0] len, widx, n;
  logic [7:0]  csum;
  logic        xfer, done;
  assign rx_ready = reset && state != S_RUN && state != S_ERR;
  assign xfer     = rx_valid && rx_ready;
  assign n        = {rx_data, len[7:0]};
  assign cpu_run  = state == S_RUN;
  assign load_err = state == S_ERR;
  // The packer's word register doubles as the write data; it is stable during the im_we cycle.
  byte_packer u_packer (
    .clk  (clk),
    .reset(reset),
    .en   (xfer && state == S_DATA),
    .din  (rx_data),
    .word (im_wdata),
    .done (done)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= S_LEN0;
      len     <= '0;
      widx    <= '0;
      csum    <= '0;
      im_we   <= 1'b0;
      im_addr <= '0;
    end else begin
      im_we <= done;
      if (done) begin
        im_addr <= widx[ADDR_W-1:0];
        widx    <= widx + 16'd1;
      end
      if (xfer)
        case (state)
          S_LEN0: begin
            len[7:0] <= rx_data;
            state    <= S_LEN1;
          end
          S_LEN1: begin
            len   <= n;
            state <= {16'd0, n} > 32'(IM_DEPTH) ? S_ERR : n == 16'd0 ? S_CSUM : S_DATA;
          end
          S_DATA: begin
            csum <= csum ^ rx_data;
            if (done && widx == len - 16'd1) state <= S_CSUM;
          end
          S_CSUM: state <= rx_data == csum ? S_RUN : S_ERR;
          default: ;
        endcase
    end
endmodule
